n64a_vdemux_gen: RTL and testbench

Parametrised video demultiplexer for the N64 digital video bus, the next generation of the front-end demux in the PPU path. It splits the time-multiplexed VD stream (one sync word, then R, G, B words per pixel) into a parallel sync+RGB pixel word. Unlike the previous generation, it tracks the word phase internally, checks pixel framing, reports lock status and flags each valid output pixel. It keeps the 15-bit truncation and deblur blanking modes and sits directly behind the input registers, feeding the scaler/OSD pipeline.

---
 rtl/n64a_vdemux_gen.sv | 101 ++++++++++
 tb/tb_n64a_vdemux_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/n64a_vdemux_gen.sv
// N64 digital video demultiplexer: splits the sync/R/G/B word stream into a
// parallel pixel word, tracking word phase, framing lock and deblur blanking.
module n64a_vdemux_gen #(
    parameter int unsigned COLOR_W   = 7,
    parameter int unsigned SYNC_W    = 4,
    parameter int unsigned TRUNC_LSB = 2,
    parameter int unsigned LOCK_PIX  = 4
) (
    input  logic                          VCLK,
    input  logic                          RST,
    input  logic                          nVDSYNC,
    input  logic [COLOR_W-1:0]            VD_i,
    input  logic                          vmode_i,
    input  logic                          ndo_deblur_i,
    input  logic                          n15bit_mode_i,
    output logic [SYNC_W+3*COLOR_W-1:0]   vdata_o,
    output logic                          pix_valid_o,
    output logic                          locked_o,
    output logic                          phase_err_o
);

    localparam int unsigned VDATA_W = SYNC_W + 3 * COLOR_W;
    localparam int unsigned CNT_W   = (LOCK_PIX + 1 > 2) ? $clog2(LOCK_PIX + 1) : 1;
    localparam logic [COLOR_W-1:0] TRUNC_MASK = ~COLOR_W'((2 ** TRUNC_LSB) - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(LOCK_PIX);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(LOCK_PIX - 1);

    logic [SYNC_W-1:0]  sync0;
    logic [COLOR_W-1:0] r0, g0, b0;
    logic [2:0]         ph;
    logic [CNT_W-1:0]   good_cnt;
    logic               nblank;
    logic [COLOR_W-1:0] chan_c;

    // Channel value as stored, with optional 15-bit truncation
    always_comb begin
        chan_c = n15bit_mode_i ? VD_i : (VD_i & TRUNC_MASK);
    end

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            vdata_o     <= '0;
            pix_valid_o <= 1'b0;
            locked_o    <= 1'b0;
            phase_err_o <= 1'b0;
            sync0       <= '0;
            r0          <= '0;
            g0          <= '0;
            b0          <= '0;
            ph          <= 3'd0;
            good_cnt    <= '0;
            nblank      <= 1'b1;
        end else begin
            pix_valid_o <= 1'b0;
            phase_err_o <= 1'b0;
            if (!nVDSYNC) begin
                // Sync word closes the pixel under assembly and starts the next
                vdata_o[SYNC_W-1:0] <= sync0;
                if (nblank) begin
                    vdata_o[VDATA_W-1:SYNC_W] <= {b0, g0, r0};
                end
                sync0 <= VD_i[SYNC_W-1:0];
                ph    <= 3'd1;

                if (ph == 3'd4) begin
                    pix_valid_o <= 1'b1;
                    if (good_cnt < CNT_MAX) begin
                        good_cnt <= good_cnt + CNT_W'(1);
                    end
                    if (good_cnt >= CNT_LAST) begin
                        locked_o <= 1'b1;
                    end
                end else if (ph != 3'd0) begin
                    phase_err_o <= 1'b1;
                    good_cnt    <= '0;
                    locked_o    <= 1'b0;
                end

                // Deblur phase: reload on rising nCSYNC, otherwise alternate
                if (ndo_deblur_i) begin
                    nblank <= 1'b1;
                end else if (!sync0[0] && VD_i[0]) begin
                    nblank <= vmode_i;
                end else begin
                    nblank <= ~nblank;
                end
            end else begin
                case (ph)
                    3'd1:    r0 <= chan_c;
                    3'd2:    g0 <= chan_c;
                    3'd3:    b0 <= chan_c;
                    default: ;
                endcase
                if (ph != 3'd0 && ph != 3'd7) begin
                    ph <= ph + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_n64a_vdemux_gen.sv
// Directed bench for n64a_vdemux_gen: framing, lock, truncation, deblur, reset.
module tb_n64a_vdemux_gen;

    localparam int unsigned COLOR_W = 7;
    localparam int unsigned SYNC_W  = 4;
    localparam int unsigned VDATA_W = SYNC_W + 3 * COLOR_W;

    logic                 VCLK = 1'b0;
    logic                 RST;
    logic                 nVDSYNC;
    logic [COLOR_W-1:0]   VD_i;
    logic                 vmode_i;
    logic                 ndo_deblur_i;
    logic                 n15bit_mode_i;
    logic [VDATA_W-1:0]   vdata_o;
    logic                 pix_valid_o;
    logic                 locked_o;
    logic                 phase_err_o;

    int n_checks = 0;
    int n_errors = 0;

    n64a_vdemux_gen #(
        .COLOR_W(7), .SYNC_W(4), .TRUNC_LSB(2), .LOCK_PIX(4)
    ) dut (
        .VCLK(VCLK), .RST(RST), .nVDSYNC(nVDSYNC), .VD_i(VD_i),
        .vmode_i(vmode_i), .ndo_deblur_i(ndo_deblur_i),
        .n15bit_mode_i(n15bit_mode_i), .vdata_o(vdata_o),
        .pix_valid_o(pix_valid_o), .locked_o(locked_o),
        .phase_err_o(phase_err_o)
    );

    always #5 VCLK = ~VCLK;

    function automatic logic [VDATA_W-1:0] pix(input logic [6:0] b, input logic [6:0] g,
                                               input logic [6:0] r, input logic [3:0] s);
        return {b, g, r, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word; returns 1 time unit after the edge that consumed it
    task automatic word(input logic nsync, input logic [6:0] d);
        nVDSYNC = nsync;
        VD_i    = d;
        @(posedge VCLK);
        #1;
        nVDSYNC = 1'b1;
    endtask

    task automatic rgb(input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
        word(1'b1, r);
        word(1'b1, g);
        word(1'b1, b);
    endtask

    initial begin
        RST = 1'b1; nVDSYNC = 1'b1; VD_i = '0;
        vmode_i = 1'b0; ndo_deblur_i = 1'b1; n15bit_mode_i = 1'b1;
        repeat (2) @(posedge VCLK);
        #1;
        chk("rst_vdata", 32'(vdata_o), 32'h0);
        chk("rst_pv", 32'(pix_valid_o), 32'h0);
        chk("rst_lock", 32'(locked_o), 32'h0);
        chk("rst_err", 32'(phase_err_o), 32'h0);
        RST = 1'b0;

        // Six well-formed pixels; first sync is unsynced
        for (int i = 0; i < 6; i++) begin
            word(1'b0, 7'h0F);
            chk("p1_pv", 32'(pix_valid_o), (i == 0) ? 32'h0 : 32'h1);
            chk("p1_err", 32'(phase_err_o), 32'h0);
            chk("p1_vdata", 32'(vdata_o),
                (i == 0) ? 32'h0 : 32'(pix(7'h33, 7'h22, 7'h11, 4'hF)));
            chk("p1_lock", 32'(locked_o), (i >= 4) ? 32'h1 : 32'h0);
            word(1'b1, 7'h11);
            if (i == 1) chk("p1_pv_pulse", 32'(pix_valid_o), 32'h0);
            word(1'b1, 7'h22);
            word(1'b1, 7'h33);
        end

        // 15-bit truncation: R = 7F stored as 7C
        n15bit_mode_i = 1'b0;
        word(1'b0, 7'h0F);
        chk("p1_last_pv", 32'(pix_valid_o), 32'h1);
        rgb(7'h7F, 7'h22, 7'h33);
        word(1'b0, 7'h0F);
        chk("trunc_vdata", 32'(vdata_o), 32'(pix(7'h30, 7'h20, 7'h7C, 4'hF)));
        chk("trunc_pv", 32'(pix_valid_o), 32'h1);
        chk("trunc_lock", 32'(locked_o), 32'h1);
        n15bit_mode_i = 1'b1;

        // Short pixel (R, G only) breaks lock
        word(1'b1, 7'h11);
        word(1'b1, 7'h22);
        word(1'b0, 7'h0F);
        chk("short_err", 32'(phase_err_o), 32'h1);
        chk("short_pv", 32'(pix_valid_o), 32'h0);
        chk("short_lock", 32'(locked_o), 32'h0);
        chk("short_vdata", 32'(vdata_o), 32'(pix(7'h30, 7'h22, 7'h11, 4'hF)));
        word(1'b1, 7'h11);
        chk("short_err_pulse", 32'(phase_err_o), 32'h0);
        word(1'b1, 7'h22);
        word(1'b1, 7'h33);
        for (int i = 0; i < 4; i++) begin
            word(1'b0, 7'h0F);
            chk("relock_pv", 32'(pix_valid_o), 32'h1);
            chk("relock_lock", 32'(locked_o), (i == 3) ? 32'h1 : 32'h0);
            rgb(7'h11, 7'h22, 7'h33);
        end
        word(1'b0, 7'h0F);

        // Deblur with vmode=0: hold, hold, update, hold, update after rising nCSYNC
        ndo_deblur_i = 1'b0;
        rgb(7'h01, 7'h02, 7'h03);
        word(1'b0, 7'h0E);
        chk("db_a", 32'(vdata_o), 32'(pix(7'h03, 7'h02, 7'h01, 4'hF)));
        rgb(7'h04, 7'h05, 7'h06);
        word(1'b0, 7'h0F);
        chk("db_b_hold", 32'(vdata_o), 32'(pix(7'h03, 7'h02, 7'h01, 4'hE)));
        rgb(7'h07, 7'h08, 7'h09);
        word(1'b0, 7'h0F);
        chk("db_c_hold", 32'(vdata_o), 32'(pix(7'h03, 7'h02, 7'h01, 4'hF)));
        rgb(7'h0A, 7'h0B, 7'h0C);
        word(1'b0, 7'h0F);
        chk("db_d_upd", 32'(vdata_o), 32'(pix(7'h0C, 7'h0B, 7'h0A, 4'hF)));
        rgb(7'h0D, 7'h0E, 7'h0F);
        word(1'b0, 7'h0F);
        chk("db_e_hold", 32'(vdata_o), 32'(pix(7'h0C, 7'h0B, 7'h0A, 4'hF)));
        rgb(7'h10, 7'h11, 7'h12);
        word(1'b0, 7'h0F);
        chk("db_f_upd", 32'(vdata_o), 32'(pix(7'h12, 7'h11, 7'h10, 4'hF)));
        ndo_deblur_i = 1'b1;

        // Asynchronous reset between G and B
        word(1'b1, 7'h21);
        word(1'b1, 7'h22);
        RST = 1'b1;
        #2;
        chk("arst_vdata", 32'(vdata_o), 32'h0);
        chk("arst_pv", 32'(pix_valid_o), 32'h0);
        chk("arst_lock", 32'(locked_o), 32'h0);
        chk("arst_err", 32'(phase_err_o), 32'h0);
        #1;
        RST = 1'b0;
        word(1'b1, 7'h23);
        word(1'b0, 7'h05);
        chk("post_rst_pv", 32'(pix_valid_o), 32'h0);
        chk("post_rst_err", 32'(phase_err_o), 32'h0);
        chk("post_rst_vdata", 32'(vdata_o), 32'h0);
        rgb(7'h41, 7'h42, 7'h43);
        word(1'b0, 7'h05);
        chk("post_rst_good", 32'(vdata_o), 32'(pix(7'h43, 7'h42, 7'h41, 4'h5)));
        chk("post_rst_good_pv", 32'(pix_valid_o), 32'h1);

        // Back-to-back sync words
        word(1'b0, 7'h05);
        chk("b2b_err", 32'(phase_err_o), 32'h1);

        // Four data words: extra word discarded, pixel flagged bad
        word(1'b1, 7'h51);
        word(1'b1, 7'h52);
        word(1'b1, 7'h53);
        word(1'b1, 7'h54);
        word(1'b0, 7'h05);
        chk("long_err", 32'(phase_err_o), 32'h1);
        chk("long_pv", 32'(pix_valid_o), 32'h0);
        chk("long_vdata", 32'(vdata_o), 32'(pix(7'h53, 7'h52, 7'h51, 4'h5)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
